// File: rtl/mips_mc_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS control FSM.
// master = control unit, slave = datapath side that supplies IR fields and stalls.
interface mips_mc_control_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               clk_enable;
    logic [5:0]         opcode;
    logic [5:0]         func_code;
    logic               rs_is_zero;
    logic               instr_waitrequest;
    logic               data_waitrequest;
    logic [2:0]         state;
    logic               active;
    logic               illegal;
    logic               instr_read;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src_jr;
    logic [5:0]         alu_op;
    logic [5:0]         alu_func;
    logic               alu_src_imm;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst_rd;
    logic               reg_write;
    logic [COUNT_W-1:0] retired;

    modport master (
        input  clk_enable, opcode, func_code, rs_is_zero, instr_waitrequest, data_waitrequest,
        output state, active, illegal, instr_read, ir_write, pc_write, pc_src_jr, alu_op,
               alu_func, alu_src_imm, mem_read, mem_write, mem_to_reg, reg_dst_rd, reg_write,
               retired
    );

    modport slave (
        output clk_enable, opcode, func_code, rs_is_zero, instr_waitrequest, data_waitrequest,
        input  state, active, illegal, instr_read, ir_write, pc_write, pc_src_jr, alu_op,
               alu_func, alu_src_imm, mem_read, mem_write, mem_to_reg, reg_dst_rd, reg_write,
               retired
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle control FSM for the ADDU/ADDIU/LW/SW/JR MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, honours memory stalls, halts on JR to
// address zero and counts retired instructions.
module mips_mc_control #(
    parameter int unsigned COUNT_W         = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input logic              clk,
    input logic              reset,
    mips_mc_control_if.master bus
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ClsNone, ClsAddu, ClsAddiu, ClsLw, ClsSw, ClsJr
    } cls_e;

    state_e             state_q, state_d;
    cls_e               cls;
    logic               illegal_q;
    logic [COUNT_W-1:0] retired_q;
    logic               retire, set_illegal;

    // Classify the instruction currently held in IR.
    always_comb begin
        cls = ClsNone;
        case (bus.opcode)
            6'b000000: begin
                if (bus.func_code == 6'b100001)      cls = ClsAddu;
                else if (bus.func_code == 6'b001000) cls = ClsJr;
            end
            6'b001001: cls = ClsAddiu;
            6'b100011: cls = ClsLw;
            6'b101011: cls = ClsSw;
            default:   cls = ClsNone;
        endcase
    end

    // Next state and datapath strobes; strobes are masked when frozen or in reset.
    always_comb begin
        state_d         = state_q;
        retire          = 1'b0;
        set_illegal     = 1'b0;
        bus.instr_read  = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src_jr   = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst_rd  = 1'b0;
        bus.reg_write   = 1'b0;
        case (state_q)
            StFetch: begin
                bus.instr_read = 1'b1;
                if (!bus.instr_waitrequest) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                if (cls == ClsNone) begin
                    set_illegal = 1'b1;
                    state_d     = HALT_ON_ILLEGAL ? StHalt : StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls)
                    ClsAddu:  state_d = StWb;
                    ClsAddiu: begin bus.alu_src_imm = 1'b1; state_d = StWb;  end
                    ClsLw:    begin bus.alu_src_imm = 1'b1; state_d = StMem; end
                    ClsSw:    begin bus.alu_src_imm = 1'b1; state_d = StMem; end
                    ClsJr: begin
                        bus.pc_write  = 1'b1;
                        bus.pc_src_jr = 1'b1;
                        retire        = 1'b1;
                        state_d       = bus.rs_is_zero ? StHalt : StFetch;
                    end
                    default:  state_d = StFetch;
                endcase
            end
            StMem: begin
                if (cls == ClsLw) begin
                    bus.mem_read = 1'b1;
                    if (!bus.data_waitrequest) state_d = StWb;
                end else if (cls == ClsSw) begin
                    bus.mem_write = 1'b1;
                    if (!bus.data_waitrequest) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    state_d = StFetch;
                end
            end
            StWb: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst_rd = (cls == ClsAddu);
                bus.mem_to_reg = (cls == ClsLw);
                retire         = 1'b1;
                state_d        = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;  // encodings 6/7 recover
        endcase
        if (reset || !bus.clk_enable) begin
            bus.instr_read  = 1'b0;
            bus.ir_write    = 1'b0;
            bus.pc_write    = 1'b0;
            bus.pc_src_jr   = 1'b0;
            bus.alu_src_imm = 1'b0;
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.mem_to_reg  = 1'b0;
            bus.reg_dst_rd  = 1'b0;
            bus.reg_write   = 1'b0;
        end
    end

    // State, sticky illegal flag and retire counter; all hold while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else if (bus.clk_enable) begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      retired_q <= retired_q + COUNT_W'(1);
        end
    end

    assign bus.state    = state_q;
    assign bus.active   = (state_q != StHalt);
    assign bus.illegal  = illegal_q;
    assign bus.retired  = retired_q;
    assign bus.alu_op   = bus.opcode;
    assign bus.alu_func = bus.func_code;
endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: the stimulus side plays instruction sequences with
// random stalls/freezes/resets and pushes the per-cycle expected outputs into a
// scoreboard; a monitor on the falling edge pops and compares. A second DUT
// (HALT_ON_ILLEGAL=1, 4-bit counter) runs on the same inputs.
module tb_mips_mc_control;
    typedef struct packed {
        logic [2:0]  state;
        logic        active;
        logic        illegal;
        logic [9:0]  strb;
        logic [5:0]  aop;
        logic [5:0]  afn;
        logic [31:0] retired;
    } obs_t;

    localparam logic [9:0] B_IR  = 10'b10_0000_0000;
    localparam logic [9:0] B_IRW = 10'b01_0000_0000;
    localparam logic [9:0] B_PCW = 10'b00_1000_0000;
    localparam logic [9:0] B_JR  = 10'b00_0100_0000;
    localparam logic [9:0] B_IMM = 10'b00_0010_0000;
    localparam logic [9:0] B_MR  = 10'b00_0001_0000;
    localparam logic [9:0] B_MW  = 10'b00_0000_1000;
    localparam logic [9:0] B_M2R = 10'b00_0000_0100;
    localparam logic [9:0] B_RD  = 10'b00_0000_0010;
    localparam logic [9:0] B_RW  = 10'b00_0000_0001;

    localparam int K_ADDU = 0, K_ADDIU = 1, K_LW = 2, K_SW = 3, K_JR = 4, K_ILL = 5;

    logic clk;
    logic reset;
    mips_mc_control_if #(.COUNT_W(32)) ifc ();
    mips_mc_control_if #(.COUNT_W(4))  ifc2 ();

    mips_mc_control #(.COUNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );
    mips_mc_control #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut2 (
        .clk(clk), .reset(reset), .bus(ifc2)
    );

    assign ifc2.clk_enable        = ifc.clk_enable;
    assign ifc2.opcode            = ifc.opcode;
    assign ifc2.func_code         = ifc.func_code;
    assign ifc2.rs_is_zero        = ifc.rs_is_zero;
    assign ifc2.instr_waitrequest = ifc.instr_waitrequest;
    assign ifc2.data_waitrequest  = ifc.data_waitrequest;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t        exp_q[$];
    obs_t        exp2_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    // reference model state
    logic [31:0] m_retired = 0;
    logic        m_illegal = 0;
    bit          m2_halted = 0;
    logic [31:0] m2_retired = 0;
    bit          halted = 0;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return (fn == 6'b100001) || (fn == 6'b001000);
        return (op == 6'b001001) || (op == 6'b100011) || (op == 6'b101011);
    endfunction

    task automatic drv(input bit i, input bit d, input bit r);
        ifc.instr_waitrequest = i;
        ifc.data_waitrequest  = d;
        ifc.rs_is_zero        = r;
    endtask

    // One clock cycle: record what both DUTs must show now, then advance the model.
    task automatic cyc(input logic [2:0] st, input logic [9:0] strb, input bit ret,
                       input bit set_ill);
        obs_t        e1, e2;
        bit          gate;
        logic [31:0] r2;
        gate       = !reset && ifc.clk_enable;
        e1.state   = st;
        e1.active  = (st != 3'd5);
        e1.illegal = m_illegal;
        e1.strb    = gate ? strb : 10'd0;
        e1.aop     = ifc.opcode;
        e1.afn     = ifc.func_code;
        e1.retired = m_retired;
        e2         = e1;
        r2         = m2_halted ? m2_retired : m_retired;
        e2.retired = {28'd0, r2[3:0]};
        if (m2_halted) begin
            e2.state   = 3'd5;
            e2.active  = 1'b0;
            e2.illegal = 1'b1;
            e2.strb    = 10'd0;
        end
        exp_q.push_back(e1);
        exp2_q.push_back(e2);
        @(posedge clk);
        #1;
        if (gate) begin
            if (set_ill) begin
                m_illegal = 1'b1;
                if (!m2_halted) begin
                    m2_halted  = 1'b1;
                    m2_retired = m_retired;
                end
            end
            if (ret) m_retired = m_retired + 1;
        end
    endtask

    task automatic freeze_cyc(input logic [2:0] st);
        ifc.clk_enable = 1'b0;
        drv(rb(), rb(), rb());
        cyc(st, 10'd0, 1'b0, 1'b0);
        ifc.clk_enable = 1'b1;
    endtask

    task automatic maybe_freeze(input logic [2:0] st);
        if ($urandom_range(0, 9) == 0)
            repeat ($urandom_range(1, 3)) freeze_cyc(st);
    endtask

    task automatic do_reset(input logic [2:0] cur, input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            drv(rb(), rb(), rb());
            cyc((i == 0) ? cur : 3'd0, 10'd0, 1'b0, 1'b0);
            m_retired  = 0;
            m_illegal  = 1'b0;
            m2_halted  = 1'b0;
            m2_retired = 0;
            halted     = 1'b0;
        end
        reset = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.opcode    = 6'($urandom);
            ifc.func_code = 6'($urandom);
            drv(rb(), rb(), rb());
            cyc(3'd5, 10'd0, 1'b0, 1'b0);
        end
    endtask

    // Plays one instruction; abort_at >= 0 resets during that MEM stall cycle.
    task automatic run_instr(input int kind, input int iw_n, input int dw_n, input bit rsz,
                             input int frz_exec, input int abort_at);
        logic [5:0] op, fn;
        logic [9:0] s;
        op = 6'($urandom);
        fn = 6'($urandom);
        case (kind)
            K_ADDU:  begin op = 6'b000000; fn = 6'b100001; end
            K_JR:    begin op = 6'b000000; fn = 6'b001000; end
            K_ADDIU: op = 6'b001001;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            default: while (is_legal(op, fn)) begin op = 6'($urandom); fn = 6'($urandom); end
        endcase
        ifc.opcode    = op;
        ifc.func_code = fn;
        for (int i = 0; i < iw_n; i++) begin
            maybe_freeze(3'd0);
            drv(1'b1, rb(), rb());
            cyc(3'd0, B_IR, 1'b0, 1'b0);
        end
        maybe_freeze(3'd0);
        drv(1'b0, rb(), rb());
        cyc(3'd0, B_IR | B_IRW | B_PCW, 1'b0, 1'b0);
        maybe_freeze(3'd1);
        drv(rb(), rb(), rb());
        cyc(3'd1, 10'd0, 1'b0, kind == K_ILL);
        if (kind == K_ILL) return;
        for (int i = 0; i < frz_exec; i++) freeze_cyc(3'd2);
        maybe_freeze(3'd2);
        s = 10'd0;
        if (kind == K_ADDIU || kind == K_LW || kind == K_SW) s = B_IMM;
        if (kind == K_JR) s = B_PCW | B_JR;
        drv(rb(), rb(), (kind == K_JR) ? rsz : rb());
        cyc(3'd2, s, kind == K_JR, 1'b0);
        if (kind == K_JR) begin
            if (rsz) halted = 1'b1;
            return;
        end
        if (kind == K_LW || kind == K_SW) begin
            s = (kind == K_LW) ? B_MR : B_MW;
            for (int i = 0; i < dw_n; i++) begin
                if (abort_at == i) begin
                    do_reset(3'd3, 2);
                    return;
                end
                maybe_freeze(3'd3);
                drv(rb(), 1'b1, rb());
                cyc(3'd3, s, 1'b0, 1'b0);
            end
            maybe_freeze(3'd3);
            drv(rb(), 1'b0, rb());
            cyc(3'd3, s, kind == K_SW, 1'b0);
            if (kind == K_SW) return;
        end
        maybe_freeze(3'd4);
        s = B_RW;
        if (kind == K_ADDU) s = s | B_RD;
        if (kind == K_LW)   s = s | B_M2R;
        drv(rb(), rb(), rb());
        cyc(3'd4, s, 1'b1, 1'b0);
    endtask

    // Scoreboard monitor: compare both DUTs away from the active edge.
    obs_t a1, a2, e1m, e2m;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e1m = exp_q.pop_front();
            e2m = exp2_q.pop_front();
            a1 = {ifc.state, ifc.active, ifc.illegal,
                  ifc.instr_read, ifc.ir_write, ifc.pc_write, ifc.pc_src_jr, ifc.alu_src_imm,
                  ifc.mem_read, ifc.mem_write, ifc.mem_to_reg, ifc.reg_dst_rd, ifc.reg_write,
                  ifc.alu_op, ifc.alu_func, ifc.retired};
            a2 = {ifc2.state, ifc2.active, ifc2.illegal,
                  ifc2.instr_read, ifc2.ir_write, ifc2.pc_write, ifc2.pc_src_jr,
                  ifc2.alu_src_imm, ifc2.mem_read, ifc2.mem_write, ifc2.mem_to_reg,
                  ifc2.reg_dst_rd, ifc2.reg_write, ifc2.alu_op, ifc2.alu_func,
                  {28'd0, ifc2.retired}};
            n_cmp++;
            if (a1 !== e1m) begin
                n_bad++;
                $display("FAIL main_dut cycle %0d: got st=%0d act=%b ill=%b strb=%b ret=%0d, want st=%0d act=%b ill=%b strb=%b ret=%0d (got %h want %h)",
                         cyc_no, a1.state, a1.active, a1.illegal, a1.strb, a1.retired,
                         e1m.state, e1m.active, e1m.illegal, e1m.strb, e1m.retired, a1, e1m);
            end
            n_cmp++;
            if (a2 !== e2m) begin
                n_bad++;
                $display("FAIL halt_dut cycle %0d: got st=%0d act=%b ill=%b strb=%b ret=%0d, want st=%0d act=%b ill=%b strb=%b ret=%0d",
                         cyc_no, a2.state, a2.active, a2.illegal, a2.strb, a2.retired,
                         e2m.state, e2m.active, e2m.illegal, e2m.strb, e2m.retired);
            end
            cyc_no++;
        end
    end

    initial begin
        int k, dw, ab;
        ifc.clk_enable = 1'b1;
        ifc.opcode     = 6'd0;
        ifc.func_code  = 6'd0;
        drv(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset(3'd0, 2);
        // directed scenarios
        run_instr(K_ADDIU, 0, 0, 1'b0, 0, -1);
        run_instr(K_ADDU,  0, 0, 1'b0, 0, -1);
        run_instr(K_LW,    0, 3, 1'b0, 0, -1);
        run_instr(K_SW,    2, 0, 1'b0, 0, -1);
        run_instr(K_JR,    0, 0, 1'b0, 0, -1);
        run_instr(K_JR,    0, 0, 1'b1, 0, -1);
        halt_cycles(10);
        do_reset(3'd5, 2);
        for (int i = 0; i < 18; i++) run_instr(K_ADDIU, 0, 0, 1'b0, 0, -1);
        do_reset(3'd0, 1);
        run_instr(K_ILL,   0, 0, 1'b0, 0, -1);
        ifc.opcode    = 6'b000100;
        run_instr(K_ADDIU, 1, 0, 1'b0, 0, -1);
        do_reset(3'd0, 1);
        run_instr(K_SW,    0, 4, 1'b0, 0, 2);
        run_instr(K_ADDU,  0, 0, 1'b0, 5, -1);
        // randomized program
        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 5);
            dw = $urandom_range(0, 3);
            ab = -1;
            if ((k == K_LW || k == K_SW) && dw > 0 && $urandom_range(0, 9) == 0)
                ab = $urandom_range(0, dw - 1);
            run_instr(k, $urandom_range(0, 2), dw, $urandom_range(0, 3) == 0,
                      ($urandom_range(0, 15) == 0) ? 2 : 0, ab);
            if (halted) begin
                halt_cycles($urandom_range(1, 4));
                do_reset(3'd5, $urandom_range(1, 2));
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle control FSM for the 5-instruction MIPS core: ADDU, ADDIU, LW, SW, JR.
- Sequences the shared datapath (PC, IR, register file, ALU, data memory) through FETCH/DECODE/EXEC/MEM/WB.
- Drives the 6-bit ALUOp/func_code pair the ALU already decodes, handles memory wait-states and halt-on-jump-to-zero, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1. When 1, an unsupported opcode halts the core. When 0, it is skipped as a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  0 = freeze FSM and counter; all strobes forced 0.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- func_code  in  6  IR[5:0].
- rs_is_zero  in  1  register rs value == 0, valid in EXEC.
- instr_waitrequest  in  1  instruction memory stall.
- data_waitrequest  in  1  data memory stall.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- active  out  1  1 until HALT.
- illegal  out  1  sticky: unsupported instruction decoded.
- instr_read  out  1  instruction fetch strobe.
- ir_write  out  1  latch IR.
- pc_write  out  1  update PC.
- pc_src_jr  out  1  PC source = rs (else PC+4).
- alu_op  out  6  to ALU ALUOp.
- alu_func  out  6  to ALU func_code.
- alu_src_imm  out  1  ALU op2 = sign-extended immediate.
- mem_read  out  1  data read strobe.
- mem_write  out  1  data write strobe.
- mem_to_reg  out  1  writeback source = memory data.
- reg_dst_rd  out  1  destination = rd (else rt).
- reg_write  out  1  register file write enable.
- retired  out  COUNT_W  retired-instruction count.

Behaviour:
- Reset: at the first edge with reset=1: state=FETCH, active=1, illegal=0, retired=0. All strobes read 0 while reset is high. Reset mid-MEM abandons the access; no reg_write follows.
- clk_enable=0: state and retired hold; every strobe is 0.
- Strobes are combinational from state, the decoded class and waitrequest. alu_op=opcode and alu_func=func_code in every state.
- FETCH:
  - instr_read=1.
  - While instr_waitrequest=1, stay in FETCH; ir_write and pc_write stay 0.
  - Otherwise ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
- DECODE, classifying {opcode,func_code}:
  - ADDU = 000000/100001.
  - JR = 000000/001000.
  - ADDIU = 001001.
  - LW = 100011.
  - SW = 101011.
  - Anything else sets illegal=1. Next state is HALT if HALT_ON_ILLEGAL=1, otherwise FETCH (not counted). Legal instructions go to EXEC.
- EXEC:
  - ADDIU, LW and SW drive alu_src_imm=1.
  - JR drives pc_write=1 and pc_src_jr=1, then retires. Next state is HALT if rs_is_zero, else FETCH. No delay slot: the target is fetched next.
  - ADDU/ADDIU go to WB; LW/SW go to MEM.
- MEM:
  - LW drives mem_read=1; SW drives mem_write=1. The strobe is held while data_waitrequest=1.
  - On the cycle data_waitrequest=0, LW goes to WB and SW retires and goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle.
  - reg_dst_rd=1 for ADDU; mem_to_reg=1 for LW.
  - Retires, then goes to FETCH.
- HALT: active=0, all strobes 0, absorbing until reset.
- retired increments by 1 on the retiring edge and wraps modulo 2^COUNT_W.
- Latency with zero wait-states:
  - ADDU/ADDIU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - JR: 3 cycles.
- Encodings 6 and 7 are unreachable and recover to FETCH.

Test Plan:
- Reset, then ADDIU (op 001001), no stalls -> states 0,1,2,4,0; alu_src_imm=1 in EXEC; one reg_write cycle with reg_dst_rd=0; retired=1.
- ADDU (op 000000, funct 100001) followed by LW with data_waitrequest=1 for 3 cycles -> mem_read high 4 cycles; WB has mem_to_reg=1; retired=2.
- SW with instr_waitrequest=1 for 2 FETCH cycles -> ir_write asserted only on the 3rd FETCH cycle; mem_write for 1 cycle; no reg_write; retired=1.
- JR with rs_is_zero=0, then JR with rs_is_zero=1 -> first returns to FETCH with pc_src_jr=1; second gives state=5, active=0, retired=2; strobes stay 0 for 10 cycles.
- Opcode 000100 with HALT_ON_ILLEGAL=1 -> illegal=1, HALT after DECODE, retired unchanged. With HALT_ON_ILLEGAL=0 -> illegal=1, back to FETCH, execution continues.
- Reset asserted in MEM during a SW stall; clk_enable=0 held 5 cycles mid-EXEC -> reset gives FETCH next edge, mem_write drops, no retire. The freeze holds state and counter, with strobes 0.
